// File: rtl/ce_div_ctrl.sv
// Programmable clock-enable generator: duty-cycled ce level plus a once-per-period tick strobe.
// New divider settings are taken in IDLE directly, or at the next period boundary while running.
module ce_div_ctrl #(
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned DEF_PERIOD = 1525,
    parameter int unsigned DEF_HIGH   = 763
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             ce,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(DEF_HIGH);

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] per_shd;
    logic [CNT_W-1:0] high_shd;

    logic             accept;
    logic             cfg_ok;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;

    assign cfg_ready = (state != StPend);
    assign busy      = (state != StIdle);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_period != '0) && (cfg_high <= cfg_period);
    // >= rather than == so a counter above the period still wraps.
    assign wrap      = (cnt >= per_act);
    assign cnt_inc   = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= '0;
            ce       <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
            per_act  <= DefPeriod;
            high_act <= DefHigh;
            per_shd  <= '0;
            high_shd <= '0;
        end else begin
            cfg_err <= accept && !cfg_ok;
            unique case (state)
                StIdle: begin
                    cnt  <= '0;
                    ce   <= 1'b0;
                    tick <= 1'b0;
                    if (accept && cfg_ok) begin
                        per_act  <= cfg_period;
                        high_act <= cfg_high;
                    end
                    if (en) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (!en) begin
                        state <= StIdle;
                        cnt   <= '0;
                        ce    <= 1'b0;
                        tick  <= 1'b0;
                        if (accept && cfg_ok) begin
                            per_act  <= cfg_period;
                            high_act <= cfg_high;
                        end
                    end else begin
                        cnt  <= wrap ? '0 : cnt_inc;
                        tick <= wrap;
                        ce   <= (cnt >= high_act);
                        // Even on a wrap cycle the shadow waits for the following wrap.
                        if (accept && cfg_ok) begin
                            per_shd  <= cfg_period;
                            high_shd <= cfg_high;
                            state    <= StPend;
                        end
                    end
                end
                StPend: begin
                    if (!en) begin
                        state    <= StIdle;
                        cnt      <= '0;
                        ce       <= 1'b0;
                        tick     <= 1'b0;
                        per_act  <= per_shd;
                        high_act <= high_shd;
                    end else begin
                        cnt  <= wrap ? '0 : cnt_inc;
                        tick <= wrap;
                        ce   <= (cnt >= high_act);
                        if (wrap) begin
                            per_act  <= per_shd;
                            high_act <= high_shd;
                            state    <= StRun;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
